// File: rtl/axil_regfile_slave.sv
// axil_regfile_slave: AXI4-Lite-style register file slave with byte strobes, SLVERR on unmapped indices and a monitor port
//   clk, rst_n                     clock, asynchronous active-low reset
//   s_aw*, s_w*, s_b*              write address / data / response channels
//   s_ar*, s_r*                    read address / data channels
//   mon_sel -> mon_data            combinational view of one register (0 when unmapped)
module axil_regfile_slave #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int NREGS = 16,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [ADDR_W-1:0]     s_awaddr,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  input  logic [DATA_W-1:0]     s_wdata,
  input  logic [DATA_W/8-1:0]   s_wstrb,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  output logic [1:0]            s_bresp,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  input  logic [ADDR_W-1:0]     s_araddr,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  output logic [DATA_W-1:0]     s_rdata,
  output logic [1:0]            s_rresp,
  input  logic [ADDR_W-1:0]     mon_sel,
  output logic [DATA_W-1:0]     mon_data
);
  localparam int NB = DATA_W / 8;
  logic [DATA_W-1:0] regs [NREGS];
  logic aw_held, w_held;
  logic [ADDR_W-1:0] aw_addr;
  logic [DATA_W-1:0] w_data;
  logic [NB-1:0] w_strb;
  function automatic logic mapped(input logic [ADDR_W-1:0] a);
    return int'(a) < NREGS;
  endfunction
  // readiness comes only from registered state, never from the valids
  assign s_awready = ~aw_held & ~s_bvalid;
  assign s_wready  = ~w_held & ~s_bvalid;
  assign s_arready = ~s_rvalid;
  assign mon_data  = mapped(mon_sel) ? regs[mon_sel] : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= RST_VAL;
      aw_held <= 1'b0;
      w_held <= 1'b0;
      aw_addr <= '0;
      w_data <= '0;
      w_strb <= '0;
      s_bvalid <= 1'b0;
      s_bresp <= 2'b00;
      s_rvalid <= 1'b0;
      s_rdata <= '0;
      s_rresp <= 2'b00;
    end else begin
      if (s_awvalid && s_awready) begin
        aw_held <= 1'b1;
        aw_addr <= s_awaddr;
      end
      if (s_wvalid && s_wready) begin
        w_held <= 1'b1;
        w_data <= s_wdata;
        w_strb <= s_wstrb;
      end
      // both halves held means neither channel is ready, so the clears here cannot race a new handshake
      if (aw_held && w_held) begin
        aw_held <= 1'b0;
        w_held <= 1'b0;
        s_bvalid <= 1'b1;
        s_bresp <= mapped(aw_addr) ? 2'b00 : 2'b10;
        if (mapped(aw_addr))
          for (int i = 0; i < NB; i++)
            if (w_strb[i]) regs[aw_addr][i*8 +: 8] <= w_data[i*8 +: 8];
      end else if (s_bvalid && s_bready) begin
        s_bvalid <= 1'b0;
      end
      // a read sampled on a commit edge sees the pre-commit contents
      if (s_arvalid && s_arready) begin
        s_rvalid <= 1'b1;
        s_rdata <= mapped(s_araddr) ? regs[s_araddr] : '0;
        s_rresp <= mapped(s_araddr) ? 2'b00 : 2'b10;
      end else if (s_rvalid && s_rready) begin
        s_rvalid <= 1'b0;
      end
    end
  end
endmodule
